// File: rtl/menu_pkg.sv
// Shared menu geometry, colours and FSM encodings so the background stage
// and the selection overlay agree on where the menu lives.
package menu_pkg;

    localparam int MENU_X    = 11;
    localparam int MENU_Y    = 12;
    localparam int MENU_W    = 200;
    localparam int MENU_H    = 256;
    localparam int ITEM_H    = 64;
    localparam int N_ITEMS   = 4;
    localparam int HL_MARGIN = 4;

    localparam logic [11:0] MENU_COLOR = 12'hf_8_0;
    localparam logic [11:0] HL_COLOR   = 12'hf_f_f;

    typedef enum logic [1:0] {
        S_MENU    = 2'd0,
        S_CONFIRM = 2'd1,
        S_START   = 2'd2
    } state_t;

endpackage

// File: rtl/menu_select_if.sv
// Pixel stream plus button and game-control signals around menu_select.
// The master side feeds timing/rgb/buttons; the slave side is the overlay stage.
interface menu_select_if;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic        btn_up;
    logic        btn_down;
    logic        btn_enter;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic [1:0]  sel_idx;
    logic        game_start;
    logic        menu_active;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        output btn_up, btn_down, btn_enter,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
        input  sel_idx, game_start, menu_active
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        input  btn_up, btn_down, btn_enter,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
        output sel_idx, game_start, menu_active
    );
endinterface

// File: rtl/btn_debounce.sv
// Synchronise a raw button, accept a new level only after it has been stable
// for DEBOUNCE_CYC cycles, and emit a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/menu_select.sv
// Menu selection stage: debounced buttons drive a cursor FSM, and the selected
// row gets a highlight bar composited onto the pixel stream with 1-clk latency.
module menu_select
    import menu_pkg::*;
#(
    parameter int          MENU_X         = menu_pkg::MENU_X,
    parameter int          MENU_Y         = menu_pkg::MENU_Y,
    parameter int          MENU_W         = menu_pkg::MENU_W,
    parameter int          ITEM_H         = menu_pkg::ITEM_H,
    parameter int          N_ITEMS        = menu_pkg::N_ITEMS,
    parameter int          HL_MARGIN      = menu_pkg::HL_MARGIN,
    parameter logic [11:0] HL_COLOR       = menu_pkg::HL_COLOR,
    parameter int          DEBOUNCE_CYC   = 650000,
    parameter int          CONFIRM_FRAMES = 32,
    parameter int          BLINK_SHIFT    = 3
) (
    input  logic         clk,
    input  logic         rst,
    menu_select_if.slave bus
);

    localparam int FRAME_W = ($clog2(CONFIRM_FRAMES + 1) > BLINK_SHIFT + 1)
                             ? $clog2(CONFIRM_FRAMES + 1) : BLINK_SHIFT + 1;

    localparam logic [10:0] X_LO   = 11'(MENU_X + 2 * HL_MARGIN);
    localparam logic [10:0] X_HI   = 11'(MENU_X + MENU_W - 1 - 2 * HL_MARGIN);
    localparam logic [10:0] Y_OFF  = 11'(MENU_Y + HL_MARGIN);
    localparam logic [10:0] Y_SPAN = 11'(ITEM_H - 1 - 2 * HL_MARGIN);

    logic up_ev, dn_ev, en_ev;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk(clk), .rst(rst), .btn(bus.btn_up), .press(up_ev)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
        .clk(clk), .rst(rst), .btn(bus.btn_down), .press(dn_ev)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_enter (
        .clk(clk), .rst(rst), .btn(bus.btn_enter), .press(en_ev)
    );

    state_t               state_q, state_d;
    logic [1:0]           cursor_q, cursor_d;
    logic [1:0]           sel_q, sel_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                 vblnk_prev_q;
    logic                 game_start_q, game_start_d;
    logic                 menu_active_q, menu_active_d;
    logic [10:0]          hcount_q, vcount_q;
    logic                 hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0]          rgb_q, rgb_d;

    logic                 vblnk_rise;
    logic                 hl_vis;
    logic                 in_box;
    logic [10:0]          y_lo, y_hi;

    always_comb begin
        vblnk_rise   = bus.vblnk_in & ~vblnk_prev_q;
        state_d      = state_q;
        cursor_d     = cursor_q;
        sel_d        = sel_q;
        frame_cnt_d  = frame_cnt_q;
        game_start_d = 1'b0;

        case (state_q)
            S_MENU: begin
                if (en_ev) begin
                    state_d     = S_CONFIRM;
                    frame_cnt_d = '0;
                end else if (up_ev && !dn_ev) begin
                    cursor_d = (cursor_q == 2'd0) ? 2'(N_ITEMS - 1) : cursor_q - 2'd1;
                end else if (dn_ev && !up_ev) begin
                    cursor_d = (cursor_q == 2'(N_ITEMS - 1)) ? 2'd0 : cursor_q + 2'd1;
                end
            end
            S_CONFIRM: begin
                if (vblnk_rise) begin
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                end
                if (frame_cnt_d == FRAME_W'(CONFIRM_FRAMES)) begin
                    game_start_d = 1'b1;
                    state_d      = S_START;
                end
            end
            default: ;
        endcase

        // Drawn selection only changes at frame boundaries to avoid tearing.
        if (vblnk_rise && state_q != S_START) begin
            sel_d = cursor_q;
        end
        menu_active_d = (state_d != S_START);
    end

    always_comb begin
        y_lo   = Y_OFF + 11'(ITEM_H) * 11'(sel_q);
        y_hi   = y_lo + Y_SPAN;
        hl_vis = (state_q == S_MENU) ||
                 ((state_q == S_CONFIRM) && !frame_cnt_q[BLINK_SHIFT]);
        in_box = (bus.hcount_in >= X_LO) && (bus.hcount_in <= X_HI) &&
                 (bus.vcount_in >= y_lo) && (bus.vcount_in <= y_hi);
        if (bus.hblnk_in || bus.vblnk_in) begin
            rgb_d = 12'h000;
        end else if (hl_vis && in_box) begin
            rgb_d = HL_COLOR;
        end else begin
            rgb_d = bus.rgb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_MENU;
            cursor_q      <= 2'd0;
            sel_q         <= 2'd0;
            frame_cnt_q   <= '0;
            vblnk_prev_q  <= 1'b0;
            game_start_q  <= 1'b0;
            menu_active_q <= 1'b1;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            sel_q         <= sel_d;
            frame_cnt_q   <= frame_cnt_d;
            vblnk_prev_q  <= bus.vblnk_in;
            game_start_q  <= game_start_d;
            menu_active_q <= menu_active_d;
            hcount_q      <= bus.hcount_in;
            vcount_q      <= bus.vcount_in;
            hsync_q       <= bus.hsync_in;
            vsync_q       <= bus.vsync_in;
            hblnk_q       <= bus.hblnk_in;
            vblnk_q       <= bus.vblnk_in;
            rgb_q         <= rgb_d;
        end
    end

    assign bus.hcount_out  = hcount_q;
    assign bus.vcount_out  = vcount_q;
    assign bus.hsync_out   = hsync_q;
    assign bus.vsync_out   = vsync_q;
    assign bus.hblnk_out   = hblnk_q;
    assign bus.vblnk_out   = vblnk_q;
    assign bus.rgb_out     = rgb_q;
    assign bus.sel_idx     = sel_q;
    assign bus.game_start  = game_start_q;
    assign bus.menu_active = menu_active_q;

endmodule

// File: tb/tb_menu_select.sv
// Directed bench for menu_select with short debounce/confirm timing.
module tb_menu_select;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    menu_select_if bus();

    menu_select #(
        .DEBOUNCE_CYC(4),
        .CONFIRM_FRAMES(4),
        .BLINK_SHIFT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic dn, input logic en, input int hold);
        bus.btn_up = up; bus.btn_down = dn; bus.btn_enter = en;
        repeat (hold) step();
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_enter = 1'b0;
        repeat (10) step();
    endtask

    task automatic vblank();
        bus.vblnk_in = 1'b1;
        step();
        step();
        bus.vblnk_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [1:0] b;
        logic [40:0] exp_v, act_v;
        rst = 1'b1;
        bus.hcount_in = 11'd5; bus.vcount_in = 11'd7; bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1; bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0;
        bus.rgb_in = 12'habc;
        step();
        step();
        checks++;
        if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.rgb_out,
             bus.sel_idx, bus.game_start, bus.menu_active} !== {11'd0, 11'd0, 2'b00, 12'd0, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state hc=%0d vc=%0d rgb=%h sel=%0d gs=%b ma=%b required all 0 with menu_active=1",
                     bus.hcount_out, bus.vcount_out, bus.rgb_out, bus.sel_idx, bus.game_start, bus.menu_active);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 2'(i);
            bus.hcount_in = 11'(100 + i); bus.vcount_in = 11'(200 + i);
            bus.hsync_in = b[0]; bus.vsync_in = b[1];
            bus.hblnk_in = ~b[0]; bus.vblnk_in = b[0]; bus.rgb_in = 12'h123;
            step();
            exp_v = {11'(100 + i), 11'(200 + i), b[0], b[1], ~b[0], b[0], 12'h000, 2'd0, 1'b0, 1'b1};
            act_v = {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out,
                     bus.vblnk_out, bus.rgb_out, bus.sel_idx, bus.game_start, bus.menu_active};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL pipe_blank_%0d got=%h required=%h", i, act_v, exp_v);
            end
        end
        bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0;
        step();
    endtask

    task automatic test_idle_pixel();
        logic [10:0] xs [4] = '{11'd19, 11'd18, 11'd202, 11'd19};
        logic [10:0] ys [4] = '{11'd16, 11'd16, 11'd71, 11'd72};
        logic [11:0] ex [4] = '{12'hfff, 12'hf52, 12'hfff, 12'hf52};
        for (int i = 0; i < 4; i++) begin
            bus.hcount_in = xs[i]; bus.vcount_in = ys[i]; bus.rgb_in = 12'hf52;
            step();
            checks++;
            if (bus.rgb_out !== ex[i]) begin
                errors++;
                $display("FAIL idle_px(%0d,%0d) rgb_out=%h required=%h", xs[i], ys[i], bus.rgb_out, ex[i]);
            end
        end
    endtask

    task automatic test_down();
        logic [10:0] xs [4] = '{11'd19, 11'd202, 11'd19, 11'd203};
        logic [10:0] ys [4] = '{11'd80, 11'd135, 11'd79, 11'd80};
        logic [11:0] ex [4] = '{12'hfff, 12'hfff, 12'hf52, 12'hf52};
        press(1'b0, 1'b1, 1'b0, 6);
        bus.hcount_in = 11'd19; bus.vcount_in = 11'd16; bus.rgb_in = 12'hf52;
        step();
        checks++;
        if (bus.rgb_out !== 12'hfff || bus.sel_idx !== 2'd0) begin
            errors++;
            $display("FAIL down_before_vblank rgb_out=%h sel=%0d required=fff sel=0", bus.rgb_out, bus.sel_idx);
        end
        vblank();
        checks++;
        if (bus.sel_idx !== 2'd1) begin
            errors++;
            $display("FAIL down_sel sel_idx=%0d required=1", bus.sel_idx);
        end
        for (int i = 0; i < 4; i++) begin
            bus.hcount_in = xs[i]; bus.vcount_in = ys[i]; bus.rgb_in = 12'hf52;
            step();
            checks++;
            if (bus.rgb_out !== ex[i]) begin
                errors++;
                $display("FAIL sel1_px(%0d,%0d) rgb_out=%h required=%h", xs[i], ys[i], bus.rgb_out, ex[i]);
            end
        end
        press(1'b0, 1'b1, 1'b0, 2);
        vblank();
        checks++;
        if (bus.sel_idx !== 2'd1) begin
            errors++;
            $display("FAIL down_glitch sel_idx=%0d required=1", bus.sel_idx);
        end
    endtask

    task automatic test_wrap();
        logic       ups [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       dns [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] ex  [5] = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            press(ups[i], dns[i], 1'b0, 6);
            vblank();
            checks++;
            if (bus.sel_idx !== ex[i]) begin
                errors++;
                $display("FAIL wrap_%0d up=%b dn=%b sel_idx=%0d required=%0d", i, ups[i], dns[i], bus.sel_idx, ex[i]);
            end
        end
        press(1'b0, 1'b1, 1'b0, 6);
        vblank();
        checks++;
        if (bus.sel_idx !== 2'd2) begin
            errors++;
            $display("FAIL move_to_2 sel_idx=%0d required=2", bus.sel_idx);
        end
    endtask

    task automatic test_confirm();
        logic [11:0] exp_px;
        press(1'b0, 1'b0, 1'b1, 6);
        bus.hcount_in = 11'd19; bus.vcount_in = 11'd144; bus.rgb_in = 12'hf52;
        step();
        checks++;
        if (bus.rgb_out !== 12'hfff || bus.menu_active !== 1'b1) begin
            errors++;
            $display("FAIL confirm_f0 rgb_out=%h ma=%b required=fff ma=1", bus.rgb_out, bus.menu_active);
        end
        for (int f = 1; f <= 3; f++) begin
            bus.vblnk_in = 1'b1;
            step();
            checks++;
            if (bus.game_start !== 1'b0) begin
                errors++;
                $display("FAIL early_game_start frame=%0d game_start=%b required=0", f, bus.game_start);
            end
            bus.vblnk_in = 1'b0;
            step();
            bus.hcount_in = 11'd19; bus.vcount_in = 11'd144; bus.rgb_in = 12'hf52;
            step();
            exp_px = (f == 1) ? 12'hfff : 12'hf52;
            checks++;
            if (bus.rgb_out !== exp_px) begin
                errors++;
                $display("FAIL blink_frame%0d rgb_out=%h required=%h", f, bus.rgb_out, exp_px);
            end
            if (f == 1) press(1'b0, 1'b1, 1'b0, 6);
        end
        bus.vblnk_in = 1'b1;
        step();
        checks++;
        if (bus.game_start !== 1'b1 || bus.menu_active !== 1'b0) begin
            errors++;
            $display("FAIL game_start_pulse gs=%b ma=%b required gs=1 ma=0", bus.game_start, bus.menu_active);
        end
        bus.vblnk_in = 1'b0;
        step();
        checks++;
        if (bus.game_start !== 1'b0 || bus.sel_idx !== 2'd2) begin
            errors++;
            $display("FAIL game_start_width gs=%b sel=%0d required gs=0 sel=2", bus.game_start, bus.sel_idx);
        end
        bus.hcount_in = 11'd19; bus.vcount_in = 11'd144; bus.rgb_in = 12'h4a7;
        step();
        checks++;
        if (bus.rgb_out !== 12'h4a7) begin
            errors++;
            $display("FAIL start_passthru rgb_out=%h required=4a7", bus.rgb_out);
        end
        press(1'b1, 1'b0, 1'b1, 6);
        vblank();
        checks++;
        if (bus.sel_idx !== 2'd2 || bus.menu_active !== 1'b0 || bus.game_start !== 1'b0) begin
            errors++;
            $display("FAIL start_ignores_btn sel=%0d ma=%b gs=%b required sel=2 ma=0 gs=0",
                     bus.sel_idx, bus.menu_active, bus.game_start);
        end
    endtask

    task automatic test_reset_mid_confirm();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        press(1'b0, 1'b1, 1'b0, 6);
        vblank();
        checks++;
        if (bus.sel_idx !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_sel sel_idx=%0d required=1", bus.sel_idx);
        end
        press(1'b0, 1'b0, 1'b1, 6);
        vblank();
        rst = 1'b1;
        step();
        checks++;
        if (bus.menu_active !== 1'b1 || bus.sel_idx !== 2'd0 || bus.game_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset ma=%b sel=%0d gs=%b required ma=1 sel=0 gs=0",
                     bus.menu_active, bus.sel_idx, bus.game_start);
        end
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            bus.vblnk_in = 1'b1;
            step();
            checks++;
            if (bus.game_start !== 1'b0 || bus.menu_active !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_frame%0d gs=%b ma=%b required gs=0 ma=1", f, bus.game_start, bus.menu_active);
            end
            bus.vblnk_in = 1'b0;
            step();
        end
        bus.hcount_in = 11'd19; bus.vcount_in = 11'd16; bus.rgb_in = 12'hf52;
        step();
        checks++;
        if (bus.rgb_out !== 12'hfff) begin
            errors++;
            $display("FAIL post_reset_hl rgb_out=%h required=fff", bus.rgb_out);
        end
    endtask

    initial begin
        bus.hcount_in = '0; bus.vcount_in = '0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
        bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0; bus.rgb_in = '0;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_enter = 1'b0;
        test_reset();
        test_idle_pixel();
        test_down();
        test_wrap();
        test_confirm();
        test_reset_mid_confirm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
